ccgc_phase_unwrap: RTL

//  Downstream consumer of the CCGC decoder's K1/K2/K3/K_valid stream. Aligns each decoded order tuple with
//  the wrapped-phase pixel from the phase-shift path, selects the fringe order with the complementary rule,

---
 rtl/ccgc_pkg.sv | 30 +++
 rtl/ccgc_sync_fifo.sv | 67 ++++++
 rtl/ccgc_phase_unwrap.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ccgc_pkg.sv
// Shared types for the CCGC phase-unwrap slice: order widths, phase regions, decoded order tuple.
package ccgc_pkg;

  localparam int unsigned K_W  = 4;
  localparam int unsigned K1_W = 3;

  typedef enum logic [1:0] {
    REG_MID = 2'b00,
    REG_HI  = 2'b01,
    REG_LO  = 2'b10
  } region_e;

  typedef struct packed {
    logic            k3;
    logic [K_W-1:0]  k2;
    logic [K1_W-1:0] k1;
  } k_tuple_t;

  localparam int unsigned TUPLE_W = $bits(k_tuple_t);

  // Top two phase bits: 10 below -pi/2, 01 at or above pi/2, 11/00 in the middle band.
  function automatic region_e region_of(input logic [1:0] top);
    case (top)
      2'b10:   return REG_LO;
      2'b01:   return REG_HI;
      default: return REG_MID;
    endcase
  endfunction

endpackage

// File: rtl/ccgc_sync_fifo.sv
// Single-clock FIFO with flush; a pop frees space for a push in the same cycle.
module ccgc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_c, do_pop_c, wr_en_c;

  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);
  assign wr_en_c   = do_push_c & ~flush;
  assign dout      = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push_c) wptr_d = wptr_q + AW'(1);
      if (do_pop_c)  rptr_d = rptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/ccgc_phase_unwrap.sv
// Pairs decoded CCGC order tuples with wrapped phase and emits absolute phase with line markers.
// Optional CCGC_UNWRAP_STATS_EN adds a per-line fringe-order jump counter.
module ccgc_phase_unwrap
  import ccgc_pkg::*;
#(
  parameter int unsigned PH_W       = 12,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LINE_W     = 1280
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  input  logic              k_valid,
  input  logic [K1_W-1:0]   k1,
  input  logic [K_W-1:0]    k2,
  input  logic              k3,
  input  logic              ph_valid,
  input  logic [PH_W-1:0]   ph_in,
  output logic              out_valid,
  output logic [PH_W+3:0]   out_phase,
  output logic [K_W-1:0]    out_k,
  output logic              out_k3,
  output logic              out_sol,
  output logic              out_eol,
`ifdef CCGC_UNWRAP_STATS_EN
  input  logic [3:0]        k_hist_sel,
  output logic [15:0]       jump_cnt,
`endif
  output logic              err_ovf,
  output logic              err_order
);

  localparam int unsigned X_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_W - 1);

  logic               fv_q, frame_start_c, pop_c;
  logic               k_push_c, ph_push_c, k_full, k_empty, ph_full, ph_empty;
  logic [TUPLE_W-1:0] k_dout;
  logic [PH_W-1:0]    ph_head;
  k_tuple_t           k_head;
  logic [K_W-1:0]     k_sel_c;
  logic               ord_err_c;

  logic               s1_valid_q, s1_valid_d, s1_k3_q, s1_k3_d;
  logic [K_W-1:0]     s1_k_q, s1_k_d;
  logic [PH_W-1:0]    s1_ph_q, s1_ph_d;
  logic               out_valid_q, out_valid_d, out_k3_q, out_k3_d;
  logic               out_sol_q, out_sol_d, out_eol_q, out_eol_d;
  logic [PH_W+3:0]    out_phase_q, out_phase_d;
  logic [K_W-1:0]     out_k_q, out_k_d;
  logic [X_W-1:0]     x_q, x_d;
  logic               err_ovf_q, err_ovf_d, err_order_q, err_order_d;

  // A rising frame envelope flushes alignment state; strobes in that cycle are discarded.
  assign frame_start_c = frame_valid & ~fv_q;
  assign k_push_c      = k_valid & ~frame_start_c;
  assign ph_push_c     = ph_valid & ~frame_start_c;
  assign pop_c         = ~k_empty & ~ph_empty & ~frame_start_c;
  assign k_head        = k_tuple_t'(k_dout);

  ccgc_sync_fifo #(.WIDTH(TUPLE_W), .DEPTH(FIFO_DEPTH)) u_k_fifo (
    .clk(clk), .rst(rst), .flush(frame_start_c), .push(k_push_c),
    .din({k3, k2, k1}), .pop(pop_c), .dout(k_dout), .full(k_full), .empty(k_empty)
  );

  ccgc_sync_fifo #(.WIDTH(PH_W), .DEPTH(FIFO_DEPTH)) u_ph_fifo (
    .clk(clk), .rst(rst), .flush(frame_start_c), .push(ph_push_c),
    .din(ph_in), .pop(pop_c), .dout(ph_head), .full(ph_full), .empty(ph_empty)
  );

  // Complementary order selection from the phase region.
  always_comb begin
    k_sel_c   = K_W'(k_head.k1);
    ord_err_c = 1'b0;
    case (region_of(ph_head[PH_W-1 -: 2]))
      REG_LO: k_sel_c = k_head.k2;
      REG_HI: begin
        if (k_head.k2 == '0) begin
          k_sel_c   = '0;
          ord_err_c = 1'b1;
        end else begin
          k_sel_c = k_head.k2 - K_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    s1_valid_d  = pop_c;
    s1_k_d      = s1_k_q;
    s1_k3_d     = s1_k3_q;
    s1_ph_d     = s1_ph_q;
    out_valid_d = s1_valid_q;
    out_phase_d = out_phase_q;
    out_k_d     = out_k_q;
    out_k3_d    = out_k3_q;
    out_sol_d   = out_sol_q;
    out_eol_d   = out_eol_q;
    x_d         = x_q;
    err_ovf_d   = err_ovf_q | (k_push_c & k_full & ~pop_c) | (ph_push_c & ph_full & ~pop_c);
    err_order_d = err_order_q | (pop_c & ord_err_c);
    if (pop_c) begin
      s1_k_d  = k_sel_c;
      s1_k3_d = k_head.k3;
      s1_ph_d = ph_head;
    end
    // Adding half-scale to a signed phase is an MSB flip, so no carry reaches the order field.
    if (s1_valid_q) begin
      out_phase_d = {s1_k_q, ~s1_ph_q[PH_W-1], s1_ph_q[PH_W-2:0]};
      out_k_d     = s1_k_q;
      out_k3_d    = s1_k3_q;
      out_sol_d   = (x_q == '0);
      out_eol_d   = (x_q == X_LAST);
      x_d         = (x_q == X_LAST) ? '0 : x_q + X_W'(1);
    end
    if (frame_start_c) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      x_d         = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q        <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_k_q      <= '0;
      s1_k3_q     <= 1'b0;
      s1_ph_q     <= '0;
      out_valid_q <= 1'b0;
      out_phase_q <= '0;
      out_k_q     <= '0;
      out_k3_q    <= 1'b0;
      out_sol_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      x_q         <= '0;
      err_ovf_q   <= 1'b0;
      err_order_q <= 1'b0;
    end else begin
      fv_q        <= frame_valid;
      s1_valid_q  <= s1_valid_d;
      s1_k_q      <= s1_k_d;
      s1_k3_q     <= s1_k3_d;
      s1_ph_q     <= s1_ph_d;
      out_valid_q <= out_valid_d;
      out_phase_q <= out_phase_d;
      out_k_q     <= out_k_d;
      out_k3_q    <= out_k3_d;
      out_sol_q   <= out_sol_d;
      out_eol_q   <= out_eol_d;
      x_q         <= x_d;
      err_ovf_q   <= err_ovf_d;
      err_order_q <= err_order_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_phase = out_phase_q;
  assign out_k     = out_k_q;
  assign out_k3    = out_k3_q;
  assign out_sol   = out_sol_q;
  assign out_eol   = out_eol_q;
  assign err_ovf   = err_ovf_q;
  assign err_order = err_order_q;

`ifdef CCGC_UNWRAP_STATS_EN
  logic [15:0] run_q, run_d, jump_cnt_q, jump_cnt_d;
  logic        jump_c;

  // Counts order steps larger than one between neighbouring pixels; published at end of line.
  always_comb begin
    jump_c     = (s1_k_q > out_k_q) ? ((s1_k_q - out_k_q) > K_W'(1))
                                    : ((out_k_q - s1_k_q) > K_W'(1));
    run_d      = run_q;
    jump_cnt_d = jump_cnt_q;
    if (frame_start_c) begin
      run_d = '0;
    end else if (s1_valid_q) begin
      if (x_q == '0)  run_d = '0;
      else if (jump_c) run_d = run_q + 16'd1;
      if (x_q == X_LAST) jump_cnt_d = run_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= '0;
      jump_cnt_q <= '0;
    end else begin
      run_q      <= run_d;
      jump_cnt_q <= jump_cnt_d;
    end
  end

  assign jump_cnt = jump_cnt_q;
`endif

endmodule
